// File: rtl/ex_mem_arbiter.sv
// ex_mem_arbiter: shares the E/M pipeline register between the stallable ALU
// path and the non-stallable multiplier pipeline. The older candidate by ROB
// age wins each cycle. Multiplier results that lose are parked in a small skid
// FIFO, because the multiplier cannot hold a finished result.
module ex_mem_arbiter #(
    parameter int WORD_SIZE       = 32,
    parameter int INSTR_TYPE_SZ   = 4,
    parameter int ROB_ENTRY_WIDTH = 4,
    parameter int MUL_BUF_DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ROB_ENTRY_WIDTH-1:0] rob_head,
    input  logic                       mem_stall,
    // ALU candidate
    input  logic                       alu_valid,
    input  logic [INSTR_TYPE_SZ-1:0]   alu_instruction_type,
    input  logic [WORD_SIZE-1:0]       alu_pc,
    input  logic [WORD_SIZE-1:0]       alu_result,
    input  logic [WORD_SIZE-1:0]       alu_s2,
    input  logic [2:0]                 alu_funct3,
    input  logic [ROB_ENTRY_WIDTH-1:0] alu_rob_id,
    output logic                       alu_stall,
    // Multiplier candidate
    input  logic                       mul_valid,
    input  logic [INSTR_TYPE_SZ-1:0]   mul_instruction_type,
    input  logic [WORD_SIZE-1:0]       mul_pc,
    input  logic [WORD_SIZE-1:0]       mul_result,
    input  logic [ROB_ENTRY_WIDTH-1:0] mul_rob_id,
    output logic                       mul_issue_stall,
    output logic                       overflow_err,
    // E/M register inputs
    output logic [INSTR_TYPE_SZ-1:0]   em_instruction_type,
    output logic [WORD_SIZE-1:0]       em_pc,
    output logic [2:0]                 em_funct3,
    output logic [WORD_SIZE-1:0]       em_aluResult,
    output logic [WORD_SIZE-1:0]       em_s2,
    output logic [ROB_ENTRY_WIDTH-1:0] em_rob_id,
    output logic                       em_valid,
    output logic                       em_stall
);

    localparam int PTR_W = (MUL_BUF_DEPTH > 1) ? $clog2(MUL_BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(MUL_BUF_DEPTH + 1);

    typedef struct packed {
        logic [INSTR_TYPE_SZ-1:0]   instr_type;
        logic [WORD_SIZE-1:0]       pc;
        logic [WORD_SIZE-1:0]       result;
        logic [ROB_ENTRY_WIDTH-1:0] rob_id;
    } mul_entry_t;

    mul_entry_t                 buf_q [MUL_BUF_DEPTH];
    logic [PTR_W-1:0]           head_q, head_d;
    logic [PTR_W-1:0]           tail_q, tail_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       overflow_q, overflow_d;

    mul_entry_t                 mul_in;
    mul_entry_t                 mul_cand;
    logic                       fifo_nonempty;
    logic                       fifo_full;
    logic                       mul_cand_valid;
    logic [ROB_ENTRY_WIDTH-1:0] alu_age;
    logic [ROB_ENTRY_WIDTH-1:0] mul_age;
    logic                       grant_alu;
    logic                       grant_mul;
    logic                       push;
    logic                       pop;
    logic                       do_write;

    assign mul_in = '{instr_type: mul_instruction_type, pc: mul_pc,
                      result: mul_result, rob_id: mul_rob_id};

    assign fifo_nonempty  = (count_q != '0);
    assign fifo_full      = (count_q == CNT_W'(MUL_BUF_DEPTH));
    assign mul_cand_valid = fifo_nonempty | mul_valid;
    // A buffered entry always goes ahead of a new arrival, keeping MUL order.
    assign mul_cand       = fifo_nonempty ? buf_q[head_q] : mul_in;

    // Ages wrap modulo 2^ROB_ENTRY_WIDTH; subtraction in the id width does that.
    assign alu_age = alu_rob_id - rob_head;
    assign mul_age = mul_cand.rob_id - rob_head;

    // Pick the older candidate when M can accept; equal ages favour the multiplier.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        grant_alu = 1'b0;
        grant_mul = 1'b0;
        if (!reset && !mem_stall) begin
            if (alu_valid && mul_cand_valid) begin
                if (mul_age <= alu_age) grant_mul = 1'b1;
                else                    grant_alu = 1'b1;
            end else if (alu_valid) begin
                grant_alu = 1'b1;
            end else if (mul_cand_valid) begin
                grant_mul = 1'b1;
            end
        end
    end

    // Skid FIFO control: pop a granted buffered entry, push any arrival not bypassed.
    always_comb begin
        pop        = grant_mul & fifo_nonempty;
        push       = mul_valid & ~(grant_mul & ~fifo_nonempty);
        do_write   = push & (~fifo_full | pop);
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (pop) head_d = head_q + PTR_W'(1);
        if (do_write) tail_d = tail_q + PTR_W'(1);
        if (do_write && !pop) count_d = count_q + CNT_W'(1);
        else if (pop && !do_write) count_d = count_q - CNT_W'(1);
        if (push && !do_write) overflow_d = 1'b1;
    end

    // Pointer, occupancy and sticky error registers; reset doubles as flush.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
        if (do_write) buf_q[tail_q] <= mul_in;
    end

    // Drive the E/M register inputs from the granted candidate.
    always_comb begin
        em_instruction_type = alu_instruction_type;
        em_pc               = alu_pc;
        em_funct3           = alu_funct3;
        em_aluResult        = alu_result;
        em_s2               = alu_s2;
        em_rob_id           = alu_rob_id;
        if (grant_mul) begin
            em_instruction_type = mul_cand.instr_type;
            em_pc               = mul_cand.pc;
            em_funct3           = 3'b000;
            em_aluResult        = mul_cand.result;
            em_s2               = '0;
            em_rob_id           = mul_cand.rob_id;
        end
    end

    assign em_valid        = grant_alu | grant_mul;
    assign em_stall        = mem_stall;
    assign alu_stall       = ~reset & alu_valid & ~grant_alu;
    // One slot of headroom absorbs a multiplier result already in flight.
    assign mul_issue_stall = ~reset & (count_q >= CNT_W'(MUL_BUF_DEPTH - 1));
    assign overflow_err    = overflow_q;

endmodule

// File: tb/tb_ex_mem_arbiter.sv
// Directed bench for ex_mem_arbiter with ROB ids 4 bits wide and a 2-entry skid FIFO.
module tb_ex_mem_arbiter;

    localparam int WS = 32;
    localparam int IT = 4;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] rob_head;
    logic          mem_stall;
    logic          alu_valid;
    logic [IT-1:0] alu_instruction_type;
    logic [WS-1:0] alu_pc, alu_result, alu_s2;
    logic [2:0]    alu_funct3;
    logic [RW-1:0] alu_rob_id;
    logic          alu_stall;
    logic          mul_valid;
    logic [IT-1:0] mul_instruction_type;
    logic [WS-1:0] mul_pc, mul_result;
    logic [RW-1:0] mul_rob_id;
    logic          mul_issue_stall;
    logic          overflow_err;
    logic [IT-1:0] em_instruction_type;
    logic [WS-1:0] em_pc, em_aluResult, em_s2;
    logic [2:0]    em_funct3;
    logic [RW-1:0] em_rob_id;
    logic          em_valid, em_stall;

    int checks = 0;
    int errors = 0;

    ex_mem_arbiter #(
        .WORD_SIZE(WS), .INSTR_TYPE_SZ(IT), .ROB_ENTRY_WIDTH(RW), .MUL_BUF_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset), .rob_head(rob_head), .mem_stall(mem_stall),
        .alu_valid(alu_valid), .alu_instruction_type(alu_instruction_type),
        .alu_pc(alu_pc), .alu_result(alu_result), .alu_s2(alu_s2),
        .alu_funct3(alu_funct3), .alu_rob_id(alu_rob_id), .alu_stall(alu_stall),
        .mul_valid(mul_valid), .mul_instruction_type(mul_instruction_type),
        .mul_pc(mul_pc), .mul_result(mul_result), .mul_rob_id(mul_rob_id),
        .mul_issue_stall(mul_issue_stall), .overflow_err(overflow_err),
        .em_instruction_type(em_instruction_type), .em_pc(em_pc),
        .em_funct3(em_funct3), .em_aluResult(em_aluResult), .em_s2(em_s2),
        .em_rob_id(em_rob_id), .em_valid(em_valid), .em_stall(em_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mul_valid = 1'b0;
        mem_stall = 1'b0;
    endtask

    task automatic set_alu(input logic [RW-1:0] id, input logic [WS-1:0] res);
        alu_valid            = 1'b1;
        alu_rob_id           = id;
        alu_result           = res;
        alu_pc               = 32'h1000 + 32'(id);
        alu_s2               = 32'h5500 + 32'(id);
        alu_funct3           = 3'd3;
        alu_instruction_type = 4'd2;
    endtask

    task automatic set_mul(input logic [RW-1:0] id, input logic [WS-1:0] res);
        mul_valid            = 1'b1;
        mul_rob_id           = id;
        mul_result           = res;
        mul_pc               = 32'h2000 + 32'(id);
        mul_instruction_type = 4'd5;
    endtask

    initial begin
        reset = 1'b1; rob_head = '0;
        alu_instruction_type = '0; alu_pc = '0; alu_result = '0; alu_s2 = '0;
        alu_funct3 = '0; alu_rob_id = '0;
        mul_instruction_type = '0; mul_pc = '0; mul_result = '0; mul_rob_id = '0;
        idle();
        step();
        step();

        // Reset state.
        reset = 1'b0;
        #1;
        check("rst_em_valid", 32'(em_valid), 0);
        check("rst_issue_stall", 32'(mul_issue_stall), 0);
        check("rst_overflow", 32'(overflow_err), 0);

        // 1. ALU only.
        set_alu(4'd5, 32'hAAAA);
        #1;
        check("t1_em_valid", 32'(em_valid), 1);
        check("t1_rob", 32'(em_rob_id), 5);
        check("t1_alu_stall", 32'(alu_stall), 0);
        check("t1_result", em_aluResult, 32'hAAAA);
        check("t1_s2", em_s2, 32'h5505);
        check("t1_funct3", 32'(em_funct3), 3);
        step();

        // 2. Conflict: MUL rob 2 older than ALU rob 3, bypass granted.
        set_alu(4'd3, 32'h3333);
        set_mul(4'd2, 32'h2222);
        #1;
        check("t2_rob", 32'(em_rob_id), 2);
        check("t2_alu_stall", 32'(alu_stall), 1);
        check("t2_result", em_aluResult, 32'h2222);
        check("t2_pc", em_pc, 32'h2002);
        check("t2_funct3", 32'(em_funct3), 0);
        check("t2_s2", em_s2, 0);
        check("t2_type", 32'(em_instruction_type), 5);
        step();
        mul_valid = 1'b0;
        #1;
        check("t2b_rob", 32'(em_rob_id), 3);
        check("t2b_alu_stall", 32'(alu_stall), 0);
        check("t2b_issue_stall", 32'(mul_issue_stall), 0);
        step();

        // Equal ages: MUL wins.
        set_alu(4'd5, 32'h5555);
        set_mul(4'd5, 32'h6666);
        #1;
        check("tie_result", em_aluResult, 32'h6666);
        check("tie_alu_stall", 32'(alu_stall), 1);
        step();

        // 3. Wrap: head 14, MUL 15 (age 1) beats ALU 1 (age 3).
        rob_head = 4'd14;
        set_alu(4'd1, 32'h0101);
        set_mul(4'd15, 32'hF0F0);
        #1;
        check("t3_rob", 32'(em_rob_id), 15);
        check("t3_alu_stall", 32'(alu_stall), 1);
        step();
        // Swapped: ALU 15 wins, MUL 1 buffered.
        set_alu(4'd15, 32'h0F0F);
        set_mul(4'd1, 32'h1111);
        #1;
        check("t3s_rob", 32'(em_rob_id), 15);
        check("t3s_alu_stall", 32'(alu_stall), 0);
        step();
        idle();
        #1;
        check("t3s_issue_stall", 32'(mul_issue_stall), 1);
        check("t3s_buf_valid", 32'(em_valid), 1);
        check("t3s_buf_rob", 32'(em_rob_id), 1);
        check("t3s_buf_result", em_aluResult, 32'h1111);
        step();
        #1;
        check("t3s_drained", 32'(mul_issue_stall), 0);
        check("t3s_idle_valid", 32'(em_valid), 0);

        // 4. mem_stall for 3 cycles with MUL results each cycle.
        rob_head = 4'd0;
        mem_stall = 1'b1;
        set_alu(4'd12, 32'hCCCC);
        set_mul(4'd7, 32'h70);
        #1;
        check("t4_em_valid", 32'(em_valid), 0);
        check("t4_em_stall", 32'(em_stall), 1);
        check("t4_alu_stall", 32'(alu_stall), 1);
        step();
        check("t4_count1_stall", 32'(mul_issue_stall), 1);
        set_mul(4'd8, 32'h80);
        step();
        check("t4_no_ovf_yet", 32'(overflow_err), 0);
        set_mul(4'd10, 32'hA0);
        step();
        check("t4_overflow", 32'(overflow_err), 1);
        check("t4_full_stall", 32'(mul_issue_stall), 1);
        mem_stall = 1'b0;
        mul_valid = 1'b0;
        #1;
        check("t4_drain0_rob", 32'(em_rob_id), 7);
        check("t4_drain0_alu_stall", 32'(alu_stall), 1);
        step();
        check("t4_drain1_rob", 32'(em_rob_id), 8);
        check("t4_drain1_result", em_aluResult, 32'h80);
        step();
        check("t4_alu_rob", 32'(em_rob_id), 12);
        check("t4_alu_stall_end", 32'(alu_stall), 0);
        check("t4_empty", 32'(mul_issue_stall), 0);
        check("t4_ovf_sticky", 32'(overflow_err), 1);
        step();
        idle();

        // 5. Buffered rob 4 granted while incoming rob 6 is pushed.
        mem_stall = 1'b1;
        set_mul(4'd4, 32'h44);
        step();
        mem_stall = 1'b0;
        set_mul(4'd6, 32'h66);
        #1;
        check("t5_rob", 32'(em_rob_id), 4);
        check("t5_result", em_aluResult, 32'h44);
        step();
        mul_valid = 1'b0;
        #1;
        check("t5_count_kept", 32'(mul_issue_stall), 1);
        check("t5_next_rob", 32'(em_rob_id), 6);
        step();
        #1;
        check("t5_empty", 32'(mul_issue_stall), 0);
        check("t5_idle", 32'(em_valid), 0);

        // 6. Reset mid-operation with two entries buffered.
        mem_stall = 1'b1;
        set_mul(4'd1, 32'h11);
        step();
        set_mul(4'd2, 32'h22);
        step();
        mul_valid = 1'b0;
        mem_stall = 1'b0;
        reset = 1'b1;
        set_alu(4'd3, 32'h33);
        #1;
        check("t6_em_valid", 32'(em_valid), 0);
        check("t6_alu_stall", 32'(alu_stall), 0);
        check("t6_issue_stall", 32'(mul_issue_stall), 0);
        step();
        reset = 1'b0;
        idle();
        #1;
        check("t6_count_cleared", 32'(mul_issue_stall), 0);
        check("t6_overflow_cleared", 32'(overflow_err), 0);
        check("t6_no_stale", 32'(em_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
